// File: rtl/subleq_loader_pkg.sv
// Shared types for the SUBLEQ program loader: word width, loader state
// encodings and the memory-write payload seen by the downstream memory.
package subleq_loader_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned BYTE_W    = 8;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [BYTE_W-1:0]    byte_t;

    // Loader states; encodings are stable so external decoders can rely on them.
    typedef enum logic [2:0] {
        LD_LEN_HI  = 3'd0,
        LD_LEN_LO  = 3'd1,
        LD_DATA_HI = 3'd2,
        LD_DATA_LO = 3'd3,
        LD_SUM_HI  = 3'd4,
        LD_SUM_LO  = 3'd5,
        LD_RUN     = 3'd6,
        LD_ERROR   = 3'd7
    } ld_state_e;

    typedef struct packed {
        word_t addr;
        word_t din;
    } mem_wr_t;

    // Big-endian byte pair to word.
    function automatic word_t word_of(input byte_t hi, input byte_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/subleq_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface subleq_loader_if;
    import subleq_loader_pkg::*;

    byte_t in_data;
    logic  in_valid;
    logic  in_ready;
    logic  mem_we;
    word_t mem_addr;
    word_t mem_din;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );

endinterface

// File: rtl/subleq_byte_pack.sv
// Assembles a hi/lo byte pair into a word. word_c exposes the pair while the
// low byte is on the bus; emitted words are registered with a one-cycle strobe.
module subleq_byte_pack
    import subleq_loader_pkg::*;
(
    input  logic  clk,
    input  logic  areset,
    input  byte_t byte_in,
    input  logic  hi_en,
    input  logic  lo_en,
    input  logic  emit,
    output word_t word_c,
    output word_t word,
    output logic  word_valid
);

    byte_t hi_q;

    assign word_c = word_of(hi_q, byte_in);

    // Only emitted words update the registered output, so it holds the last data word.
    always_ff @(posedge clk) begin
        if (areset) begin
            hi_q       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= lo_en && emit;
            if (hi_en) begin
                hi_q <= byte_in;
            end
            if (lo_en && emit) begin
                word <= word_c;
            end
        end
    end

endmodule

// File: rtl/subleq_loader.sv
// Streams a length-prefixed, checksummed SUBLEQ image into memory, holding the
// CPU in reset until the image is written and verified.
module subleq_loader
    import subleq_loader_pkg::*;
#(
    parameter word_t ADDR_BASE = '0,
    parameter bit    CHECK_EN  = 1'b1
)
(
    input  logic            clk,
    input  logic            areset,
    subleq_loader_if.slave  bus,
    output logic            cpu_reset,
    output logic            done,
    output logic            err
);

    ld_state_e state_q;
    ld_state_e state_d;

    logic  ready_c;
    logic  xfer_c;
    logic  hi_en_c;
    logic  lo_en_c;
    logic  emit_c;
    word_t word_c;

    word_t words_left_q;
    word_t index_q;
    word_t sum_q;
    word_t addr_q;

    assign xfer_c = bus.in_valid && ready_c;

    subleq_byte_pack u_pack (
        .clk        (clk),
        .areset     (areset),
        .byte_in    (bus.in_data),
        .hi_en      (hi_en_c),
        .lo_en      (lo_en_c),
        .emit       (emit_c),
        .word_c     (word_c),
        .word       (bus.mem_din),
        .word_valid (bus.mem_we)
    );

    assign bus.in_ready = ready_c;
    assign bus.mem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= LD_LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and byte-steering decode; every transition needs a handshake.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        hi_en_c = 1'b0;
        lo_en_c = 1'b0;
        emit_c  = 1'b0;

        case (state_q)
            LD_LEN_HI: begin
                ready_c = 1'b1;
                hi_en_c = xfer_c;
                if (xfer_c) state_d = LD_LEN_LO;
            end
            LD_LEN_LO: begin
                ready_c = 1'b1;
                lo_en_c = xfer_c;
                if (xfer_c) state_d = (word_c == '0) ? LD_SUM_HI : LD_DATA_HI;
            end
            LD_DATA_HI: begin
                ready_c = 1'b1;
                hi_en_c = xfer_c;
                if (xfer_c) state_d = LD_DATA_LO;
            end
            LD_DATA_LO: begin
                ready_c = 1'b1;
                lo_en_c = xfer_c;
                emit_c  = 1'b1;
                if (xfer_c) state_d = (words_left_q == WORD_SIZE'(1)) ? LD_SUM_HI : LD_DATA_HI;
            end
            LD_SUM_HI: begin
                ready_c = 1'b1;
                hi_en_c = xfer_c;
                if (xfer_c) state_d = LD_SUM_LO;
            end
            LD_SUM_LO: begin
                ready_c = 1'b1;
                lo_en_c = xfer_c;
                if (xfer_c) state_d = ((word_c == sum_q) || !CHECK_EN) ? LD_RUN : LD_ERROR;
            end
            LD_RUN: begin
                state_d = LD_RUN;
            end
            LD_ERROR: begin
                state_d = LD_ERROR;
            end
        endcase
    end

    // Counters, running checksum, write address and CPU control flags.
    always_ff @(posedge clk) begin
        if (areset) begin
            words_left_q <= '0;
            index_q      <= '0;
            sum_q        <= '0;
            addr_q       <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (lo_en_c && (state_q == LD_LEN_LO)) begin
                words_left_q <= word_c;
            end
            if (lo_en_c && (state_q == LD_DATA_LO)) begin
                words_left_q <= words_left_q - WORD_SIZE'(1);
                index_q      <= index_q + WORD_SIZE'(1);
                sum_q        <= sum_q + word_c;
                addr_q       <= ADDR_BASE + index_q;
            end
            cpu_reset <= (state_d != LD_RUN);
            done      <= (state_d == LD_RUN);
            err       <= (state_d == LD_ERROR);
        end
    end

endmodule

// File: tb/tb_subleq_loader.sv
// Scoreboard bench for subleq_loader: directed byte streams, expected memory
// writes queued at stimulus time and checked by per-instance write monitors.
module tb_subleq_loader;
    import subleq_loader_pkg::*;

    typedef byte_t byte_q_t[$];

    logic clk;
    logic areset;
    logic cpu_reset0, done0, err0;
    logic cpu_reset1, done1, err1;

    int checks;
    int failures;

    mem_wr_t exp0[$];
    mem_wr_t exp1[$];

    subleq_loader_if bus0 ();
    subleq_loader_if bus1 ();

    subleq_loader #(.ADDR_BASE(16'h0000), .CHECK_EN(1'b1)) u_dut0 (
        .clk       (clk),
        .areset    (areset),
        .bus       (bus0),
        .cpu_reset (cpu_reset0),
        .done      (done0),
        .err       (err0)
    );

    subleq_loader #(.ADDR_BASE(16'hFFFF), .CHECK_EN(1'b0)) u_dut1 (
        .clk       (clk),
        .areset    (areset),
        .bus       (bus1),
        .cpu_reset (cpu_reset1),
        .done      (done1),
        .err       (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitors: every mem_we must match the oldest queued write.
    always @(negedge clk) begin
        mem_wr_t e;
        if (bus0.mem_we === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr0_unexpected: got addr=%h din=%h expected no write", bus0.mem_addr, bus0.mem_din);
            end else begin
                e = exp0.pop_front();
                chk("wr0", {bus0.mem_addr, bus0.mem_din}, {e.addr, e.din});
            end
        end
        if (bus1.mem_we === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr1_unexpected: got addr=%h din=%h expected no write", bus1.mem_addr, bus1.mem_din);
            end else begin
                e = exp1.pop_front();
                chk("wr1", {bus1.mem_addr, bus1.mem_din}, {e.addr, e.din});
            end
        end
    end

    task automatic do_reset(input int cycles);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        areset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input byte_t b, input int max_gap);
        int   gap;
        logic rdy;
        bit   ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            bus0.in_valid = 1'b0;
            bus1.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        if (sel) begin
            bus1.in_data  = b;
            bus1.in_valid = 1'b1;
        end else begin
            bus0.in_data  = b;
            bus0.in_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = sel ? bus1.in_ready : bus0.in_ready;
            @(posedge clk);
            #1;
            ok = (rdy === 1'b1);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got no handshake for byte %h expected accept", b);
        end
    endtask

    task automatic send_stream(input bit sel, input byte_q_t s, input int max_gap);
        foreach (s[i]) send_byte(sel, s[i], max_gap);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic push0(input word_t a, input word_t d);
        mem_wr_t e;
        e.addr = a;
        e.din  = d;
        exp0.push_back(e);
    endtask

    task automatic push1(input word_t a, input word_t d);
        mem_wr_t e;
        e.addr = a;
        e.din  = d;
        exp1.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pending0"}, 32'(exp0.size()), 32'd0);
        chk({name, "_pending1"}, 32'(exp1.size()), 32'd0);
    endtask

    initial begin
        byte_q_t s;
        checks   = 0;
        failures = 0;
        bus0.in_data  = '0;
        bus0.in_valid = 1'b0;
        bus1.in_data  = '0;
        bus1.in_valid = 1'b0;

        // Reset state
        do_reset(2);
        chk("rst_cpu_reset", 32'(cpu_reset0), 32'd1);
        chk("rst_done",      32'(done0),      32'd0);
        chk("rst_err",       32'(err0),       32'd0);
        chk("rst_mem_we",    32'(bus0.mem_we), 32'd0);
        chk("rst_mem_addr",  32'(bus0.mem_addr), 32'd0);
        chk("rst_mem_din",   32'(bus0.mem_din),  32'd0);
        chk("rst_in_ready",  32'(bus0.in_ready), 32'd1);
        chk("rst1_mem_addr", 32'(bus1.mem_addr), 32'd0);

        // Three-word image, valid held high, good checksum
        push0(16'd0, 16'h000A);
        push0(16'd1, 16'h000B);
        push0(16'd2, 16'h000C);
        s = '{8'h00, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h00, 8'h0C, 8'h00};
        send_stream(1'b0, s, 0);
        chk("t1_pending_before_sum", 32'(exp0.size()), 32'd0);
        chk("t1_cpu_held", 32'(cpu_reset0), 32'd1);
        send_byte(1'b0, 8'h21, 0);
        bus0.in_valid = 1'b0;
        chk("t1_cpu_reset", 32'(cpu_reset0), 32'd0);
        chk("t1_done",      32'(done0),      32'd1);
        chk("t1_err",       32'(err0),       32'd0);
        chk("t1_in_ready",  32'(bus0.in_ready), 32'd0);
        drain("t1");
        chk("t1_done_hold", 32'(done0), 32'd1);

        // areset while running re-holds the CPU
        do_reset(1);
        chk("t1_rerst_cpu_reset", 32'(cpu_reset0), 32'd1);
        chk("t1_rerst_done",      32'(done0),      32'd0);

        // Same image, bad checksum
        push0(16'd0, 16'h000A);
        push0(16'd1, 16'h000B);
        push0(16'd2, 16'h000C);
        s = '{8'h00, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h00, 8'h0C, 8'h00, 8'h22};
        send_stream(1'b0, s, 0);
        chk("t2_err",       32'(err0),       32'd1);
        chk("t2_cpu_reset", 32'(cpu_reset0), 32'd1);
        chk("t2_done",      32'(done0),      32'd0);
        drain("t2");
        chk("t2_in_ready",  32'(bus0.in_ready), 32'd0);
        chk("t2_err_hold",  32'(err0),       32'd1);

        // Empty image
        do_reset(1);
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(1'b0, s, 0);
        chk("t3_done",      32'(done0),      32'd1);
        chk("t3_err",       32'(err0),       32'd0);
        chk("t3_cpu_reset", 32'(cpu_reset0), 32'd0);
        drain("t3");

        // Checksum disabled: wrong sum still runs
        do_reset(1);
        s = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        send_stream(1'b1, s, 0);
        chk("t3b_done", 32'(done1), 32'd1);
        chk("t3b_err",  32'(err1),  32'd0);

        // Checksum disabled, base FFFF: address wraps to 0
        do_reset(1);
        push1(16'hFFFF, 16'h1234);
        push1(16'h0000, 16'hFFFF);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h12, 8'h00};
        send_stream(1'b1, s, 2);
        chk("t3c_done",      32'(done1),      32'd1);
        chk("t3c_err",       32'(err1),       32'd0);
        chk("t3c_cpu_reset", 32'(cpu_reset1), 32'd0);
        drain("t3c");

        // Random gaps, checksum overflow 1234+FFFF = 1233
        do_reset(1);
        push0(16'd0, 16'h1234);
        push0(16'd1, 16'hFFFF);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h12, 8'h33};
        send_stream(1'b0, s, 5);
        chk("t4_done", 32'(done0), 32'd1);
        chk("t4_err",  32'(err0),  32'd0);
        drain("t4");

        // Abort mid-load after the high byte of word 1, then a fresh image
        do_reset(1);
        push0(16'd0, 16'h00AA);
        s = '{8'h00, 8'h02, 8'h00, 8'hAA, 8'h00};
        send_stream(1'b0, s, 0);
        do_reset(1);
        chk("t5_abort_ready",     32'(bus0.in_ready), 32'd1);
        chk("t5_abort_cpu_reset", 32'(cpu_reset0),   32'd1);
        chk("t5_abort_addr",      32'(bus0.mem_addr), 32'd0);
        push0(16'd0, 16'h0007);
        s = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h07};
        send_stream(1'b0, s, 0);
        chk("t5_done", 32'(done0), 32'd1);
        chk("t5_err",  32'(err0),  32'd0);
        drain("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
